// File: rtl/top_k_result_drain.sv
// Top-k chain read-out: snapshots the unit registers at end of query, streams them
// largest-first on an AXI-Stream master, then hands one clear token to the chain head.
module top_k_result_drain #(
    parameter int INTEGER_SIZE = 32,
    parameter int K            = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [K*INTEGER_SIZE-1:0] reg_data,
    input  logic [K-1:0]              reg_valid,
    input  logic                      query_done,
    output logic [INTEGER_SIZE-1:0]   m_axis_TDATA,
    output logic                      m_axis_TVALID,
    input  logic                      m_axis_TREADY,
    output logic                      m_axis_TLAST,
    output logic [INTEGER_SIZE:0]     clear_TDATA,
    output logic                      clear_TVALID,
    input  logic                      clear_TREADY,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IW = $clog2(K) + 1;
    localparam int AW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_CLEAR
    } state_t;

    state_t                  r_state;
    logic [INTEGER_SIZE-1:0] r_shadow [K];
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           r_n;

    logic [IW-1:0]           w_n;
    logic                    w_run;
    logic [IW-1:0]           w_next_idx;
    logic [AW-1:0]           w_rd_sel;
    logic                    w_beat;
    logic                    w_clr_hs;

    // Only the unbroken run of valid units from the head holds real results.
    always_comb begin
        w_n   = '0;
        w_run = 1'b1;
        for (int i = 0; i < K; i++) begin
            if (w_run && reg_valid[i]) begin
                w_n = w_n + IW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_next_idx  = r_idx + IW'(1);
    assign w_rd_sel    = AW'(w_next_idx);
    assign w_beat      = m_axis_TVALID & m_axis_TREADY;
    assign w_clr_hs    = clear_TVALID & clear_TREADY;
    assign clear_TDATA = {1'b1, {INTEGER_SIZE{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_n           <= '0;
            m_axis_TDATA  <= '0;
            m_axis_TVALID <= 1'b0;
            m_axis_TLAST  <= 1'b0;
            clear_TVALID  <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            for (int i = 0; i < K; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            // The CLEAR handshake cycle still counts as busy.
            if (query_done && r_state != S_IDLE) begin
                overrun <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (query_done) begin
                        for (int i = 0; i < K; i++) begin
                            r_shadow[i] <= reg_data[i*INTEGER_SIZE +: INTEGER_SIZE];
                        end
                        r_n   <= w_n;
                        r_idx <= '0;
                        busy  <= 1'b1;
                        if (w_n != '0) begin
                            r_state       <= S_SEND;
                            m_axis_TDATA  <= reg_data[INTEGER_SIZE-1:0];
                            m_axis_TVALID <= 1'b1;
                            m_axis_TLAST  <= (w_n == IW'(1));
                        end else begin
                            r_state      <= S_CLEAR;
                            clear_TVALID <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_beat) begin
                        if (m_axis_TLAST) begin
                            r_state       <= S_CLEAR;
                            m_axis_TVALID <= 1'b0;
                            m_axis_TLAST  <= 1'b0;
                            clear_TVALID  <= 1'b1;
                        end else begin
                            r_idx        <= w_next_idx;
                            m_axis_TDATA <= r_shadow[w_rd_sel];
                            m_axis_TLAST <= (w_next_idx == r_n - IW'(1));
                        end
                    end
                end
                S_CLEAR: begin
                    if (w_clr_hs) begin
                        r_state      <= S_IDLE;
                        clear_TVALID <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    m_axis_TVALID <= 1'b0;
                    m_axis_TLAST  <= 1'b0;
                    clear_TVALID  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_k_result_drain.sv
// Scoreboard bench for top_k_result_drain (K=4): stimulus queues expected beats,
// a negedge monitor pops and compares on every m_axis / clear handshake.
module tb_top_k_result_drain;

    localparam int W = 32;
    localparam int K = 4;
    localparam logic [W:0] CLR_TOK = {1'b1, {W{1'b0}}};

    logic             clk;
    logic             rst;
    logic [K*W-1:0]   reg_data;
    logic [K-1:0]     reg_valid;
    logic             query_done;
    logic [W-1:0]     m_axis_TDATA;
    logic             m_axis_TVALID;
    logic             m_axis_TREADY;
    logic             m_axis_TLAST;
    logic [W:0]       clear_TDATA;
    logic             clear_TVALID;
    logic             clear_TREADY;
    logic             busy;
    logic             overrun;

    typedef struct {
        bit         clr;
        logic [W:0] d;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    top_k_result_drain #(.INTEGER_SIZE(W), .K(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_data     (reg_data),
        .reg_valid    (reg_valid),
        .query_done   (query_done),
        .m_axis_TDATA (m_axis_TDATA),
        .m_axis_TVALID(m_axis_TVALID),
        .m_axis_TREADY(m_axis_TREADY),
        .m_axis_TLAST (m_axis_TLAST),
        .clear_TDATA  (clear_TDATA),
        .clear_TVALID (clear_TVALID),
        .clear_TREADY (clear_TREADY),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes happen at the next posedge, so negedge sampling is safe.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m_axis_TVALID && m_axis_TREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {32'd0, m_axis_TDATA}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_kind", 64'(e.clr), 64'd0);
                    check("beat_data", {32'd0, m_axis_TDATA}, 64'(e.d[W-1:0]));
                    check("beat_last", 64'(m_axis_TLAST), 64'(e.last));
                end
            end
            if (clear_TVALID && clear_TREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_clear", 64'(clear_TDATA), 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("clear_kind", 64'(e.clr), 64'd1);
                    check("clear_data", 64'(clear_TDATA), 64'(e.d));
                end
            end
        end
    end

    task automatic push_beat(input logic [W-1:0] d, input bit last);
        exp_t e;
        e.clr = 1'b0; e.d = {1'b0, d}; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        exp_t e;
        e.clr = 1'b1; e.d = CLR_TOK; e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    // Pulse query_done; inputs are driven 1 unit after a posedge.
    task automatic pulse(input logic [K-1:0] v, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic [W-1:0] d3);
        @(posedge clk) #1;
        reg_valid  = v;
        reg_data   = {d3, d2, d1, d0};
        query_done = 1'b1;
        @(posedge clk) #1;
        query_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check(name, 64'(exp_q.size() != 0 || busy), 64'd0);
    endtask

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        reg_data = '0;
        reg_valid = '0;
        query_done = 1'b0;
        m_axis_TREADY = 1'b1;
        clear_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_TVALID), 64'd0);
        check("rst_tdata", 64'(m_axis_TDATA), 64'd0);
        check("rst_clear_v", 64'(clear_TVALID), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: full throughput, first beat the cycle after the query_done edge
        push_beat(90, 0); push_beat(70, 0); push_beat(50, 0); push_beat(10, 1);
        push_clear();
        pulse(4'b1111, 90, 70, 50, 10);
        check("s1_latency", 64'(m_axis_TVALID), 64'd1);
        check("s1_clear_tok", 64'(clear_TDATA), 64'(CLR_TOK));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s1_consecutive", 64'(m_axis_TVALID), 64'd1);
        end
        @(negedge clk);
        check("s1_clear_next", 64'(clear_TVALID), 64'd1);
        check("s1_no_beat", 64'(m_axis_TVALID), 64'd0);
        @(negedge clk);
        check("s1_clear_once", 64'(clear_TVALID), 64'd0);
        check("s1_idle", 64'(busy), 64'd0);
        wait_idle("s1_done", 20);

        // 2: TREADY pattern 1,0,0,1,...
        push_beat(90, 0); push_beat(70, 0); push_beat(50, 0); push_beat(10, 1);
        push_clear();
        pulse(4'b1111, 90, 70, 50, 10);
        for (int c = 0; c < 16; c++) begin
            m_axis_TREADY = pat[c % 4];
            @(posedge clk) #1;
        end
        m_axis_TREADY = 1'b1;
        wait_idle("s2_done", 20);

        // 3: partial valid run, and a gap that must cut the run at one unit
        push_beat(40, 0); push_beat(30, 1); push_clear();
        pulse(4'b0011, 40, 30, 99, 88);
        wait_idle("s3_done", 20);
        push_beat(77, 1); push_clear();
        pulse(4'b0101, 77, 66, 55, 44);
        wait_idle("s3b_done", 20);

        // 4: nothing valid -> clear only, busy for one cycle
        push_clear();
        pulse(4'b0000, 1, 2, 3, 4);
        check("s4_no_beat", 64'(m_axis_TVALID), 64'd0);
        check("s4_clear_v", 64'(clear_TVALID), 64'd1);
        check("s4_busy", 64'(busy), 64'd1);
        @(posedge clk) #1;
        check("s4_busy_drop", 64'(busy), 64'd0);
        check("s4_clear_drop", 64'(clear_TVALID), 64'd0);
        wait_idle("s4_done", 10);

        // 5: second query_done while stalled in SEND with new data
        m_axis_TREADY = 1'b0;
        push_beat(11, 0); push_beat(22, 0); push_beat(33, 0); push_beat(44, 1);
        push_clear();
        pulse(4'b1111, 11, 22, 33, 44);
        pulse(4'b1111, 5, 6, 7, 8);
        reg_data = {32'd1, 32'd2, 32'd3, 32'd4};
        check("s5_overrun", 64'(overrun), 64'd1);
        check("s5_hold", 64'(m_axis_TDATA), 64'd11);
        m_axis_TREADY = 1'b1;
        wait_idle("s5_done", 20);
        check("s5_sticky", 64'(overrun), 64'd1);

        // 6: reset after the 2nd beat of a full-rate drain
        push_beat(90, 0); push_beat(70, 0); push_beat(50, 0); push_beat(10, 1);
        push_clear();
        pulse(4'b1111, 90, 70, 50, 10);
        @(posedge clk);
        @(posedge clk) #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("s6_async_tvalid", 64'(m_axis_TVALID), 64'd0);
        check("s6_async_tdata", 64'(m_axis_TDATA), 64'd0);
        check("s6_async_busy", 64'(busy), 64'd0);
        check("s6_overrun_clr", 64'(overrun), 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("s6_no_residual", 64'(m_axis_TVALID | clear_TVALID), 64'd0);
        push_beat(8, 0); push_beat(7, 0); push_beat(6, 0); push_beat(5, 1);
        push_clear();
        pulse(4'b1111, 8, 7, 6, 5);
        wait_idle("s6_done", 20);
        check("s6_overrun_low", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
